// File: rtl/echo_ticks_to_mm.sv
// Converts echo pulse widths (50 MHz ticks) to millimetres with a bit-serial
// shift-add multiply, and keeps a moving average of the last 2^AVG_LOG2 distances.
module echo_ticks_to_mm #(
  parameter int MUL      = 225,
  parameter int MUL_W    = 9,
  parameter int SHIFT    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int DIST_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [20:0]       in_ticks,
  input  logic              in_valid,
  input  logic              in_timeout,
  input  logic              overrun_clr,
  output logic [DIST_W-1:0] dist_mm,
  output logic [DIST_W-1:0] avg_mm,
  output logic              out_valid,
  output logic              out_of_range,
  output logic              busy,
  output logic              overrun
);

  localparam int TICK_W = 21;
  localparam int ACC_W  = TICK_W + MUL_W;
  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = DIST_W + AVG_LOG2;
  localparam int IDX_W  = $clog2(MUL_W + 1);
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam logic [MUL_W-1:0]  MUL_C    = MUL_W'(MUL);
  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_AVG  = 2'd2
  } state_t;

  state_t              state_r, state_nx_s;
  logic [TICK_W-1:0]   ticks_r;
  logic [ACC_W-1:0]    acc_r;
  logic [IDX_W-1:0]    idx_r;
  logic [DIST_W-1:0]   hist_r [DEPTH];
  logic [SUM_W-1:0]    sum_r;
  logic [FILL_W-1:0]   fill_r;

  logic                start_s, tmo_s;
  logic [ACC_W-1:0]    part_s, acc_shift_s;
  logic [DIST_W-1:0]   mm_s, avg_s;
  logic [SUM_W-1:0]    sum_new_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state logic; a valid strobe wins over a simultaneous timeout
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          start_s    = 1'b1;
          state_nx_s = ST_MUL;
        end else if (in_timeout) begin
          tmo_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (idx_r == IDX_W'(MUL_W - 1)) state_nx_s = ST_AVG;
        else                            state_nx_s = ST_MUL;
      end
      ST_AVG:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Partial product, saturating conversion and running-sum update
  always_comb begin
    part_s      = MUL_C[idx_r] ? (ACC_W'(ticks_r) << idx_r) : '0;
    acc_shift_s = acc_r >> SHIFT;
    if (|acc_shift_s[ACC_W-1:DIST_W]) mm_s = DIST_MAX;
    else                              mm_s = acc_shift_s[DIST_W-1:0];
    sum_new_s = sum_r + SUM_W'(mm_s) - SUM_W'(hist_r[DEPTH-1]);
    // history becomes full with this sample once DEPTH-1 are already held
    if (fill_r >= FILL_W'(DEPTH - 1)) avg_s = DIST_W'(sum_new_s >> AVG_LOG2);
    else                              avg_s = mm_s;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticks_r      <= '0;
      acc_r        <= '0;
      idx_r        <= '0;
      sum_r        <= '0;
      fill_r       <= '0;
      dist_mm      <= '0;
      avg_mm       <= '0;
      out_valid    <= 1'b0;
      out_of_range <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_r[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      busy      <= (state_nx_s != ST_IDLE);
      if ((state_r != ST_IDLE) && (in_valid || in_timeout)) overrun <= 1'b1;
      else if (overrun_clr)                                 overrun <= 1'b0;

      if (start_s) begin
        ticks_r <= in_ticks;
        acc_r   <= '0;
        idx_r   <= '0;
      end else if (tmo_s) begin
        out_valid    <= 1'b1;
        out_of_range <= 1'b1;
        dist_mm      <= DIST_MAX;
      end else if (state_r == ST_MUL) begin
        acc_r <= acc_r + part_s;
        idx_r <= idx_r + IDX_W'(1);
      end else if (state_r == ST_AVG) begin
        dist_mm   <= mm_s;
        avg_mm    <= avg_s;
        sum_r     <= sum_new_s;
        hist_r[0] <= mm_s;
        for (int i = 1; i < DEPTH; i++) hist_r[i] <= hist_r[i-1];
        if (fill_r < FILL_W'(DEPTH)) fill_r <= fill_r + FILL_W'(1);
        out_of_range <= 1'b0;
        out_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_ticks_to_mm.sv
// Directed + randomized bench for echo_ticks_to_mm against an arithmetic model
// (mm = floor(ticks*225/65536), queue-based moving average).
module tb_echo_ticks_to_mm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] in_ticks = 21'd0;
  logic        in_valid = 1'b0;
  logic        in_timeout = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [13:0] dist_mm, avg_mm;
  logic        out_valid, out_of_range, busy, overrun;

  int n_cmp = 0;
  int n_err = 0;
  int hist_q[$];
  int exp_avg = 0;

  always #10 clk = ~clk;

  echo_ticks_to_mm dut (
    .clk(clk), .rst_n(rst_n), .in_ticks(in_ticks), .in_valid(in_valid),
    .in_timeout(in_timeout), .overrun_clr(overrun_clr), .dist_mm(dist_mm),
    .avg_mm(avg_mm), .out_valid(out_valid), .out_of_range(out_of_range),
    .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int model_mm(input int t);
    longint p;
    p = (longint'(t) * 225) >>> 16;
    return (p > 16383) ? 16383 : int'(p);
  endfunction

  // Push a distance into the model history and return the expected average
  function automatic int model_push(input int mm);
    int s;
    hist_q.push_front(mm);
    if (hist_q.size() > 4) void'(hist_q.pop_back());
    if (hist_q.size() < 4) return mm;
    s = 0;
    foreach (hist_q[i]) s += hist_q[i];
    return s / 4;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_timeout = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist_q.delete();
    exp_avg = 0;
  endtask

  task automatic do_sample(input int t, input bit with_tmo, input string tag);
    int lat, busy_cnt, e_mm;
    e_mm = model_mm(t);
    @(negedge clk);
    in_ticks = 21'(t); in_valid = 1'b1; in_timeout = with_tmo;
    @(negedge clk);
    in_valid = 1'b0; in_timeout = 1'b0;
    lat = 0; busy_cnt = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    exp_avg = model_push(e_mm);
    check({tag, "_latency"}, lat, 10);
    check({tag, "_busy_cycles"}, busy_cnt, 10);
    check({tag, "_dist"}, dist_mm, e_mm);
    check({tag, "_avg"}, avg_mm, exp_avg);
    check({tag, "_oor"}, out_of_range, 0);
    check({tag, "_busy_at_out"}, busy, 0);
    @(negedge clk);
    check({tag, "_strobe_1cyc"}, out_valid, 0);
  endtask

  task automatic do_timeout(input string tag);
    @(negedge clk);
    in_timeout = 1'b1;
    @(negedge clk);
    in_timeout = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_dist"}, dist_mm, 16383);
    check({tag, "_oor"}, out_of_range, 1);
    check({tag, "_avg_hold"}, avg_mm, exp_avg);
    @(negedge clk);
    check({tag, "_strobe_1cyc"}, out_valid, 0);
    check({tag, "_oor_hold"}, out_of_range, 1);
  endtask

  initial begin
    int pulses, cap;
    repeat (2) @(negedge clk);
    check("rst_dist", dist_mm, 0);
    check("rst_avg", avg_mm, 0);
    check("rst_valid", out_valid, 0);
    check("rst_oor", out_of_range, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    do_sample(100000, 1'b0, "first");
    check("first_343", dist_mm, 343);
    do_sample(0, 1'b0, "zero");
    check("zero_lit", dist_mm, 0);
    do_sample(2097151, 1'b0, "max_ticks");
    check("max_lit", dist_mm, 7199);

    do_reset();
    do_sample(100000, 1'b0, "seq1");
    do_sample(200000, 1'b0, "seq2");
    do_sample(300000, 1'b0, "seq3");
    do_sample(400000, 1'b0, "seq4");
    check("seq4_avg_lit", avg_mm, 857);
    do_sample(100000, 1'b0, "seq5");
    check("seq5_avg_lit", avg_mm, 857);

    do_timeout("tmo");
    do_sample(100000, 1'b0, "after_tmo");

    // second strobe lands while busy: dropped, flags overrun
    @(negedge clk);
    in_ticks = 21'd250000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_ticks = 21'd50000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pulses = 0; cap = -1;
    for (int i = 0; i < 25; i++) begin
      if (out_valid === 1'b1) begin pulses++; cap = int'(dist_mm); end
      @(negedge clk);
    end
    exp_avg = model_push(model_mm(250000));
    check("ovr_pulses", pulses, 1);
    check("ovr_dist", cap, model_mm(250000));
    check("ovr_avg", avg_mm, exp_avg);
    check("ovr_flag", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);

    do_sample(150000, 1'b1, "both_strobes");
    check("both_overrun", overrun, 0);

    // reset in the middle of a multiply
    @(negedge clk);
    in_ticks = 21'd300000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_dist", dist_mm, 0);
    check("midrst_avg", avg_mm, 0);
    check("midrst_busy", busy, 0);
    check("midrst_oor", out_of_range, 0);
    hist_q.delete();
    exp_avg = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    check("midrst_no_valid", pulses, 0);
    do_sample(100000, 1'b0, "post_rst");
    check("post_rst_avg_lit", avg_mm, 343);

    // randomized samples with occasional timeouts and idle gaps
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) do_timeout("rnd_tmo");
      do_sample(int'($urandom_range(0, 2097151)), 1'(($urandom_range(0, 7) == 0)), "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/echo_ticks_to_mm.md
Name: echo_ticks_to_mm

Overview:
Downstream stage of the HC-SR04 echo pulse-width counter. It consumes the counter's width_ticks/valid/timeout strobes and converts each 50 MHz tick count to millimetres using a sequential shift-add multiply by a fixed-point constant. It keeps a 4-sample moving average and presents distance, average and an out-of-range flag to the display/UART logic, with a one-cycle output strobe.

Parameters:
MUL, 225, fixed-point scale numerator; mm = (ticks*MUL) >> SHIFT (225/65536 ≈ 343 m/s / 2 / 50 MHz)
MUL_W, 9, bit width of MUL; equals the number of multiply iterations
SHIFT, 16, right shift applied to the product (truncating)
AVG_LOG2, 2, log2 of the averaging depth (4 samples)
DIST_W, 14, width of the distance outputs

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
in_ticks  in  21  measured echo width in clk ticks; sampled when in_valid=1
in_valid  in  1  one-cycle strobe: new measurement
in_timeout  in  1  one-cycle strobe: echo timed out
overrun_clr  in  1  synchronous clear of the overrun flag
dist_mm  out  DIST_W  latest converted distance
avg_mm  out  DIST_W  moving average of the last 2^AVG_LOG2 valid distances
out_valid  out  1  one-cycle strobe: dist_mm, avg_mm and out_of_range updated
out_of_range  out  1  1 = last output came from a timeout; held until the next output
busy  out  1  1 while state != IDLE
overrun  out  1  sticky: a strobe arrived while busy and was dropped

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset: all outputs 0, state IDLE, history entries 0, running sum 0, fill count 0.
- FSM has three states: IDLE, MUL, AVG.
- IDLE, in_valid=1: latch in_ticks, clear the 30-bit accumulator, clear the bit index, go to MUL. in_valid takes priority when in_valid and in_timeout are both high.
- IDLE, in_timeout=1 only: on the next edge pulse out_valid=1, set out_of_range=1, set dist_mm to all ones (2^DIST_W-1). avg_mm, history and fill count are unchanged. State stays IDLE. Latency is 1 edge.
- MUL: runs MUL_W cycles. At iteration i, if MUL[i]=1 then acc += ticks<<i. After the last iteration go to AVG. No combinational multiplier is used.
- AVG, single edge:
  - mm = acc>>SHIFT, saturated to 2^DIST_W-1 if wider.
  - dist_mm <= mm.
  - Shift mm into the 2^AVG_LOG2 history and update sum = sum + mm − oldest. sum is DIST_W+AVG_LOG2 bits.
  - Fill count saturates at 2^AVG_LOG2.
  - avg_mm <= sum_new>>AVG_LOG2 when the history is full, otherwise avg_mm <= mm.
  - out_of_range <= 0; out_valid <= 1; state goes to IDLE.
- Latency: out_valid is high in the cycle after edge k+MUL_W+1, where edge k is the edge that sampled in_valid (default: 10 edges).
- busy is high from edge k until the out_valid cycle. In the out_valid cycle state is IDLE, so a new strobe is accepted in that cycle.
- Any in_valid or in_timeout strobe while busy=1 is dropped and sets overrun. Only reset or overrun_clr clears overrun; set has priority over clear in the same cycle.
- out_valid is a single-cycle strobe. dist_mm, avg_mm and out_of_range hold between strobes.
- Reset mid-operation aborts the conversion immediately: no out_valid, and history is cleared.

Test Plan:
- Reset, then in_ticks=100000 with in_valid -> exactly 10 edges later a single out_valid pulse; dist_mm=343, avg_mm=343, out_of_range=0, busy high for 10 cycles.
- in_ticks=0 -> dist_mm=0. in_ticks=2097151 -> dist_mm=7199, no saturation.
- Sequence 100000, 200000, 300000, 400000 -> dist_mm 343, 686, 1029, 1373. avg_mm 343, 686, 1029, then 857. A fifth sample of 100000 -> avg_mm=(686+1029+1373+343)>>2=857.
- in_timeout alone -> out_valid next cycle, dist_mm=16383, out_of_range=1, avg_mm unchanged. A following in_valid=100000 -> out_of_range=0.
- in_valid, then in_valid again 3 cycles later -> second strobe dropped, overrun=1, only one out_valid. overrun_clr -> overrun=0. in_valid and in_timeout in the same cycle -> treated as valid.
- Assert rst_n=0 during MUL -> all outputs 0, no out_valid. The next sample (ticks 100000) gives avg_mm=343, proving the history was cleared.
